// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner
// Reads back the NUM_OF_NONCES final h0 words written by the hasher, compares
// each against the difficulty target, tracks the winning nonce and writes a
// two-word report {best_nonce, best_hash} to report_addr.
//
// Optional build macro: SCAN_EARLY_EXIT_EN
//   defined   : the first hit ends the scan and becomes the winner.
//   undefined : all words are scanned and the minimum hit hash wins
//               (ties keep the lower nonce).
//
// state  | meaning
// IDLE   | waiting for start, done=1, results held
// READ   | issue read k, compare word returned for k-1
// DRAIN  | compare last word, no new read
// WRITE0 | write best_nonce to report_addr
// WRITE1 | write best_hash to report_addr+1
module nonce_result_scanner #(
  parameter int NUM_OF_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  logic [15:0] report_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] best_nonce,
  output logic [31:0] best_hash,
  output logic [7:0]  hit_count,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] WRITE0 = 3'd3;
  localparam logic [2:0] WRITE1 = 3'd4;

  localparam logic [7:0] LAST_IDX = 8'(NUM_OF_NONCES - 1);

  logic [2:0]  state;
  logic [7:0]  k;
  logic [15:0] res_base;
  logic [15:0] rep_base;
  logic [31:0] tgt;

  logic        cmp_valid;
  logic        hit;
  logic [7:0]  cmp_idx;

  assign mem_clk = clk;
  assign done    = (state == IDLE);

  // Word on mem_read_data belongs to the read issued one cycle earlier; in
  // DRAIN k has already advanced to N so k-1 is still the right nonce.
  always_comb begin
    cmp_valid = ((state == READ) && (k != 8'd0)) || (state == DRAIN);
    cmp_idx   = k - 8'd1;
    hit       = cmp_valid && (mem_read_data < tgt);
  end

  // Memory port is decoded straight from the state so the read address and
  // write strobes line up with the state they belong to.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    case (state)
      READ: begin
        mem_addr = res_base + {8'd0, k};
      end
      WRITE0: begin
        mem_we         = 1'b1;
        mem_addr       = rep_base;
        mem_write_data = best_nonce;
      end
      WRITE1: begin
        mem_we         = 1'b1;
        mem_addr       = rep_base + 16'd1;
        mem_write_data = best_hash;
      end
      default: ;
    endcase
  end

  // Sequencer, result tracking and synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 8'd0;
      res_base   <= 16'd0;
      rep_base   <= 16'd0;
      tgt        <= 32'd0;
      found      <= 1'b0;
      best_nonce <= 32'd0;
      best_hash  <= 32'hFFFF_FFFF;
      hit_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            res_base   <= result_addr;
            rep_base   <= report_addr;
            tgt        <= target;
            found      <= 1'b0;
            best_nonce <= 32'd0;
            best_hash  <= 32'hFFFF_FFFF;
            hit_count  <= 8'd0;
            k          <= 8'd0;
            state      <= READ;
          end
        end
        READ: begin
          k <= k + 8'd1;
          if (k == LAST_IDX) state <= DRAIN;
        end
        DRAIN:   state <= WRITE0;
        WRITE0:  state <= WRITE1;
        WRITE1:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (hit) begin
        found <= 1'b1;
`ifdef SCAN_EARLY_EXIT_EN
        // First hit wins outright and cuts the scan short.
        hit_count  <= 8'd1;
        best_nonce <= {24'd0, cmp_idx};
        best_hash  <= mem_read_data;
        state      <= WRITE0;
`else
        if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
        // Strict compare: nonces arrive in ascending order, so a tie keeps
        // the earlier (lower) nonce.
        if (mem_read_data < best_hash) begin
          best_nonce <= {24'd0, cmp_idx};
          best_hash  <= mem_read_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner (NUM_OF_NONCES=16): memory model,
// write log, per-cycle port checks and end-of-scan result checks.
module tb_nonce_result_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] result_addr;
  logic [15:0] report_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [31:0] best_nonce;
  logic [31:0] best_hash;
  logic [7:0]  hit_count;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:65535];
  logic [15:0] wl_addr [0:63];
  logic [31:0] wl_data [0:63];
  int          wcount = 0;

  always #5 clk = ~clk;

  nonce_result_scanner #(.NUM_OF_NONCES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .result_addr(result_addr), .report_addr(report_addr), .target(target),
    .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
    .hit_count(hit_count), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Synchronous-read memory; writes are logged rather than stored.
  always @(posedge mem_clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) begin
      wl_addr[wcount[5:0]] <= mem_addr;
      wl_data[wcount[5:0]] <= mem_write_data;
      wcount <= wcount + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input logic ef, input logic [31:0] en,
                                    input logic [31:0] eh, input logic [7:0] ec);
    check("done", {31'd0, done}, 32'd1);
    check("found", {31'd0, found}, {31'd0, ef});
    check("best_nonce", best_nonce, en);
    check("best_hash", best_hash, eh);
    check("hit_count", {24'd0, hit_count}, {24'd0, ec});
  endtask

  // Runs one scan. exp_len = cycles done stays low; rst_at / restart_at
  // (-1 = unused) pulse reset / start at that cycle of the scan.
  task automatic run_scan(input logic [15:0] res, input logic [15:0] rep,
                          input logic [31:0] tgt, input int exp_len,
                          input int rst_at, input int restart_at,
                          input logic ef, input logic [31:0] en,
                          input logic [31:0] eh, input logic [7:0] ec);
    int cnt;
    int w0;
    w0 = wcount;
    @(negedge clk);
    result_addr = res;
    report_addr = rep;
    target      = tgt;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (!done && cnt < 100) begin
      if (cnt < exp_len - 2) begin
        check("read_we", {31'd0, mem_we}, 32'd0);
        if (cnt < 16) check("read_addr", {16'd0, mem_addr}, {16'd0, 16'(res + 16'(cnt))});
      end else if (cnt == exp_len - 2) begin
        check("wr0_we", {31'd0, mem_we}, 32'd1);
        check("wr0_addr", {16'd0, mem_addr}, {16'd0, rep});
        check("wr0_data", mem_write_data, en);
      end else if (cnt == exp_len - 1) begin
        check("wr1_we", {31'd0, mem_we}, 32'd1);
        check("wr1_addr", {16'd0, mem_addr}, {16'd0, 16'(rep + 16'd1)});
        check("wr1_data", mem_write_data, eh);
      end
      reset = (cnt == rst_at);
      start = (cnt == restart_at);
      cnt++;
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    if (rst_at >= 0) begin
      check("reset_len", cnt, rst_at + 1);
      check("reset_writes", wcount - w0, 0);
      check_idle_outputs(1'b0, 32'd0, 32'hFFFF_FFFF, 8'd0);
    end else begin
      check("done_len", cnt, exp_len);
      check("num_writes", wcount - w0, 2);
      check("log_addr0", {16'd0, wl_addr[w0[5:0]]}, {16'd0, rep});
      check("log_data0", wl_data[w0[5:0]], en);
      check("log_addr1", {16'd0, wl_addr[6'(w0 + 1)]}, {16'd0, 16'(rep + 16'd1)});
      check("log_data1", wl_data[6'(w0 + 1)], eh);
      check_idle_outputs(ef, en, eh, ec);
    end
    repeat (2) @(negedge clk);
    check_idle_outputs(ef, ef ? en : 32'd0, ef ? eh : 32'hFFFF_FFFF, ec);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    result_addr = 16'd0;
    report_addr = 16'd0;
    target = 32'd0;

    for (int k = 0; k < 16; k++) begin
      mem[16'h0100 + 16'(k)] = 32'h1000_0000 + 32'(k);
      mem[16'h0300 + 16'(k)] = 32'hFFFF_FFF0;
      mem[16'h0400 + 16'(k)] = 32'h8000_0000;
      mem[16'hFFF8 + 16'(k)] = 32'h0000_0200 - 32'(16 * k);
      mem[16'h0600 + 16'(k)] = 32'hFFFF_FFFF;
      mem[16'h0700 + 16'(k)] = 32'h0000_0000;
    end
    mem[16'h0305] = 32'h0000_0040;
    mem[16'h0309] = 32'h0000_0010;
    mem[16'h0403] = 32'h0000_0007;
    mem[16'h040C] = 32'h0000_0007;
    mem[16'h060A] = 32'hFFFF_FFFE;

    repeat (3) @(negedge clk);
    check_idle_outputs(1'b0, 32'd0, 32'hFFFF_FFFF, 8'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    reset = 1'b0;

    // No hits
    run_scan(16'h0100, 16'h0200, 32'h0000_0100, 19, -1, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 8'd0);
`ifdef SCAN_EARLY_EXIT_EN
    run_scan(16'h0300, 16'h0210, 32'h0000_1000, 9, -1, -1, 1'b1, 32'd5, 32'h40, 8'd1);
    run_scan(16'h0400, 16'h0220, 32'h0000_0100, 7, -1, -1, 1'b1, 32'd3, 32'h7, 8'd1);
`else
    run_scan(16'h0300, 16'h0210, 32'h0000_1000, 19, -1, -1, 1'b1, 32'd9, 32'h10, 8'd2);
    run_scan(16'h0400, 16'h0220, 32'h0000_0100, 19, -1, -1, 1'b1, 32'd3, 32'h7, 8'd2);
`endif
    // Reset at cycle 7 aborts with no writes, then a clean rerun
    run_scan(16'h0100, 16'h0230, 32'h0000_0100, 19, 7, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 8'd0);
    run_scan(16'h0100, 16'h0240, 32'h0000_0100, 19, -1, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 8'd0);
    // Address wrap plus ignored restart pulse
`ifdef SCAN_EARLY_EXIT_EN
    run_scan(16'hFFF8, 16'h0500, 32'h0000_1000, 4, -1, 3, 1'b1, 32'd0, 32'h200, 8'd1);
    run_scan(16'h0600, 16'h0250, 32'hFFFF_FFFF, 14, -1, -1, 1'b1, 32'd10, 32'hFFFF_FFFE, 8'd1);
`else
    run_scan(16'hFFF8, 16'h0500, 32'h0000_1000, 19, -1, 3, 1'b1, 32'd15, 32'h110, 8'd16);
    run_scan(16'h0600, 16'h0250, 32'hFFFF_FFFF, 19, -1, -1, 1'b1, 32'd10, 32'hFFFF_FFFE, 8'd1);
`endif
    // target=0 never hits
    run_scan(16'h0700, 16'h0260, 32'h0000_0000, 19, -1, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
